// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage definitions: stall encoding, bus widths, reset vector
// and the branch / IF-to-ID bundle layouts.
package inst_fetch_unit_pkg;

    localparam int          STALL_WD         = 6;
    localparam logic        STOP             = 1'b1;
    localparam logic        NO_STOP          = 1'b0;
    localparam int          IF_TO_ID_WD      = 33;
    localparam int          BR_WD            = 33;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_id_t;

endpackage

// File: rtl/if_inst_hold.sv
// One-entry hold buffer that keeps the returned instruction stable for
// decode while ID is stalled.
module if_inst_hold
    import inst_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic [31:0] rdata,
    output logic [31:0] inst_out
);

    logic        hold_v;
    logic [31:0] hold_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v    <= 1'b0;
            hold_inst <= '0;
        end else if (stall_id == STOP) begin
            if (!hold_v) begin
                hold_inst <= rdata;
                hold_v    <= 1'b1;
            end
        end else begin
            hold_v <= 1'b0;
        end
    end

    // Reset forces the raw SRAM path even if a capture is still live.
    assign inst_out = (hold_v && !rst) ? hold_inst : rdata;

endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage: PC, redirect handling, SRAM read issue and hold buffer.
// Optional per-cycle fetch/redirect counters under IF_FETCH_CNT_EN.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]            id_inst
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0]            fetch_cnt,
    output logic [31:0]            redirect_cnt
`endif
);

    localparam logic [31:0] PC_INIT = RESET_PC - 32'd4;

    br_bus_t     br;
    if_id_t      ifid;
    logic [31:0] pc_r;
    logic [31:0] next_pc;
    logic [31:0] br_pend_addr;
    logic        ce_r;
    logic        br_pend;
    logic        unused_stall;

    assign br           = br_bus;
    assign unused_stall = ^stall[STALL_WD-1:2];

    always_comb begin
        next_pc = pc_r + 32'd4;
        if (br.br_e) begin
            next_pc = br.br_addr;
        end else if (br_pend) begin
            next_pc = br_pend_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= PC_INIT;
            ce_r         <= 1'b0;
            br_pend      <= 1'b0;
            br_pend_addr <= '0;
        end else if (stall[0] == NO_STOP) begin
            pc_r    <= next_pc;
            ce_r    <= 1'b1;
            br_pend <= 1'b0;
        end else if (br.br_e) begin
            // Latest redirect seen during an IF stall wins.
            br_pend      <= 1'b1;
            br_pend_addr <= br.br_addr;
        end
    end

    always_comb begin
        ifid.ce = ce_r;
        ifid.pc = pc_r;
        if (rst) begin
            ifid.ce = 1'b0;
            ifid.pc = PC_INIT;
        end
    end

    assign if_to_id_bus    = ifid;
    assign inst_sram_en    = ifid.ce;
    assign inst_sram_addr  = ifid.pc;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_wdata = 32'b0;

    if_inst_hold u_hold (
        .clk      (clk),
        .rst      (rst),
        .stall_id (stall[1]),
        .rdata    (inst_sram_rdata),
        .inst_out (id_inst)
    );

`ifdef IF_FETCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else if (stall[0] == NO_STOP) begin
            if (ce_r) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (br.br_e || br_pend) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
`else
    // Counters not built.
`endif

endmodule
